reaction_timer_datapath: RTL and testbench

REACTION_TIMER_DATAPATH -- requirements
Module: reaction_timer_datapath

---
 rtl/reaction_timer_datapath_if.sv | 19 +
 rtl/reaction_timer_datapath.sv | 80 ++++++++
 tb/tb_reaction_timer_datapath.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_datapath_if.sv
// reaction_timer_datapath_if: controller<->datapath bundle; master drives starts/time controls, slave returns done pulses and time_ms
interface reaction_timer_datapath_if #(parameter int TW = 10);
   logic          start_rwait;
   logic          start_wait5;
   logic          time_clr;
   logic          time_en;
   logic          rwait_done;
   logic          wait5_done;
   logic          time_late;
   logic [TW-1:0] time_ms;
   modport master (
      output start_rwait, start_wait5, time_clr, time_en,
      input  rwait_done, wait5_done, time_late, time_ms
   );
   modport slave (
      input  start_rwait, start_wait5, time_clr, time_en,
      output rwait_done, wait5_done, time_late, time_ms
   );
endinterface

// File: rtl/reaction_timer_datapath.sv
// reaction_timer_datapath: ms-tick random/fixed wait timers and saturating reaction counter; ports clk, rst (async active-low), bus (slave: starts/time controls in, done pulses/time_ms out)
module reaction_timer_datapath #(
   parameter int CLK_HZ       = 100000000,
   parameter int RWAIT_MIN_MS = 2000,
   parameter int RAND_BITS    = 11,
   parameter int WAIT5_MS     = 5000,
   parameter int LATE_MS      = 1000,
   parameter int TW           = 10
) (
   input logic                      clk,
   input logic                      rst,
   reaction_timer_datapath_if.slave bus
);
   localparam int TICK_DIV = CLK_HZ / 1000;
   localparam int PW       = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int RCW      = $clog2(RWAIT_MIN_MS + 2 ** RAND_BITS);
   localparam int WCW      = $clog2(WAIT5_MS + 1);
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   logic [15:0]    lfsr_q, lfsr_d;
   logic [PW-1:0]  rp_q, rp_d, wp_q, wp_d, tp_q, tp_d;
   logic [RCW-1:0] rc_q, rc_d, rt_q, rt_d;
   logic [WCW-1:0] wc_q, wc_d;
   logic [TW-1:0]  tms_q, tms_d;
   logic           ra_q, ra_d, wa_q, wa_d;
   logic           rdone_q, rdone_d, wdone_q, wdone_d, late_q, late_d;
   logic           r_tick, w_tick, t_tick;
   always_comb begin
      lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      r_tick  = ra_q && rp_q == PMAX;
      rp_d    = bus.start_rwait || !ra_q || r_tick ? '0 : rp_q + 1'b1;
      rc_d    = bus.start_rwait ? '0 : r_tick ? rc_q + 1'b1 : rc_q;
      rt_d    = bus.start_rwait ? RCW'(RWAIT_MIN_MS) + RCW'(lfsr_q[RAND_BITS-1:0]) : rt_q;
      rdone_d = !bus.start_rwait && r_tick && rc_q + 1'b1 == rt_q;
      ra_d    = bus.start_rwait || (ra_q && !rdone_d);
      w_tick  = wa_q && wp_q == PMAX;
      wp_d    = bus.start_wait5 || !wa_q || w_tick ? '0 : wp_q + 1'b1;
      wc_d    = bus.start_wait5 ? '0 : w_tick ? wc_q + 1'b1 : wc_q;
      wdone_d = !bus.start_wait5 && w_tick && wc_q + 1'b1 == WCW'(WAIT5_MS);
      wa_d    = bus.start_wait5 || (wa_q && !wdone_d);
      t_tick  = bus.time_en && tp_q == PMAX && tms_q < TW'(LATE_MS);
      tp_d    = bus.time_clr ? '0 : !bus.time_en ? tp_q : tp_q == PMAX ? '0 : tp_q + 1'b1;
      tms_d   = bus.time_clr ? '0 : t_tick ? tms_q + 1'b1 : tms_q;
      late_d  = !bus.time_clr && t_tick && tms_q == TW'(LATE_MS - 1);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q  <= 16'hACE1;
         rp_q    <= '0;
         wp_q    <= '0;
         tp_q    <= '0;
         rc_q    <= '0;
         rt_q    <= '0;
         wc_q    <= '0;
         tms_q   <= '0;
         ra_q    <= 1'b0;
         wa_q    <= 1'b0;
         rdone_q <= 1'b0;
         wdone_q <= 1'b0;
         late_q  <= 1'b0;
      end else begin
         lfsr_q  <= lfsr_d;
         rp_q    <= rp_d;
         wp_q    <= wp_d;
         tp_q    <= tp_d;
         rc_q    <= rc_d;
         rt_q    <= rt_d;
         wc_q    <= wc_d;
         tms_q   <= tms_d;
         ra_q    <= ra_d;
         wa_q    <= wa_d;
         rdone_q <= rdone_d;
         wdone_q <= wdone_d;
         late_q  <= late_d;
      end
   end
   assign bus.rwait_done = rdone_q;
   assign bus.wait5_done = wdone_q;
   assign bus.time_late  = late_q;
   assign bus.time_ms    = tms_q;
endmodule

// File: tb/tb_reaction_timer_datapath.sv
// tb_reaction_timer_datapath: randomized and directed checks against an event-time reference model
module tb_reaction_timer_datapath;
   localparam int TD   = 4;
   localparam int RMIN = 3;
   localparam int RB   = 2;
   localparam int W5   = 5;
   localparam int LATE = 6;
   localparam int TW   = 10;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int total = 0;
   int bad = 0;
   int e = 0;
   int r_due, w_due, en_cnt, exp_ms;
   bit exp_r, exp_w, exp_l;
   logic [15:0] lfsr_m;
   reaction_timer_datapath_if #(.TW(TW)) bus ();
   reaction_timer_datapath #(
      .CLK_HZ(4000), .RWAIT_MIN_MS(RMIN), .RAND_BITS(RB),
      .WAIT5_MS(W5), .LATE_MS(LATE), .TW(TW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic b;
      b = v[0] ^ v[2] ^ v[3] ^ v[5];
      return (v >> 1) | (16'(b) << 15);
   endfunction
   function automatic logic [12:0] got_v();
      return {bus.rwait_done, bus.wait5_done, bus.time_late, bus.time_ms};
   endfunction
   function automatic logic [12:0] want_v();
      return {exp_r, exp_w, exp_l, 10'(exp_ms)};
   endfunction
   task automatic model_rst();
      r_due = -1;
      w_due = -1;
      en_cnt = 0;
      exp_ms = 0;
      exp_r = 0;
      exp_w = 0;
      exp_l = 0;
      lfsr_m = 16'hACE1;
   endtask
   task automatic step();
      @(posedge clk);
      e++;
      if (!rst) model_rst();
      else begin
         exp_r = r_due == e && !bus.start_rwait;
         if (r_due == e) r_due = -1;
         if (bus.start_rwait) r_due = e + (RMIN + int'(lfsr_m % (1 << RB))) * TD;
         exp_w = w_due == e && !bus.start_wait5;
         if (w_due == e) w_due = -1;
         if (bus.start_wait5) w_due = e + W5 * TD;
         if (bus.time_clr) en_cnt = 0;
         else if (bus.time_en) en_cnt++;
         exp_l = !bus.time_clr && bus.time_en && en_cnt == LATE * TD;
         exp_ms = en_cnt / TD < LATE ? en_cnt / TD : LATE;
         lfsr_m = lfsr_next(lfsr_m);
      end
      #1;
   endtask
   task automatic drive_idle();
      bus.start_rwait = 0;
      bus.start_wait5 = 0;
      bus.time_clr = 0;
      bus.time_en = 0;
   endtask
   task automatic do_reset();
      rst = 0;
      drive_idle();
      model_rst();
      repeat (2) step();
      rst = 1;
   endtask
   task automatic test_reset();
      bus.start_wait5 = 1;
      bus.time_en = 1;
      repeat (30) step();
      drive_idle();
      #2 rst = 0;
      #1 model_rst();
      total++;
      if (got_v() !== 13'd0) begin
         bad++;
         $display("FAIL reset_async: got %h want 0", got_v());
      end
      repeat (2) begin
         step();
         total++;
         if (got_v() !== want_v()) begin
            bad++;
            $display("FAIL reset_hold: got %h want %h", got_v(), want_v());
         end
      end
      rst = 1;
   endtask
   task automatic test_first_rwait();
      int n = 0, at = -1;
      bus.start_rwait = 1;
      step();
      bus.start_rwait = 0;
      for (int i = 1; i <= 22; i++) begin
         step();
         if (bus.rwait_done) begin n++; at = i; end
         total++;
         if (got_v() !== want_v()) begin
            bad++;
            $display("FAIL first_rwait_cyc%0d: got %h want %h", i, got_v(), want_v());
         end
      end
      total++;
      if (n != 1 || at != 16) begin
         bad++;
         $display("FAIL first_rwait_latency: got %0d pulses at %0d, want 1 at 16", n, at);
      end
   endtask
   task automatic test_wait5();
      int n = 0, at = -1, rn = 0;
      bus.start_wait5 = 1;
      step();
      bus.start_wait5 = 0;
      for (int i = 1; i <= 26; i++) begin
         step();
         if (bus.wait5_done) begin n++; at = i; end
         if (bus.rwait_done) rn++;
         total++;
         if (got_v() !== want_v()) begin
            bad++;
            $display("FAIL wait5_cyc%0d: got %h want %h", i, got_v(), want_v());
         end
      end
      total++;
      if (n != 1 || at != 20 || rn != 0) begin
         bad++;
         $display("FAIL wait5_latency: got %0d pulses at %0d rwait %0d, want 1 at 20 rwait 0", n, at, rn);
      end
   endtask
   task automatic test_time_sat();
      int n = 0, at = -1;
      bus.time_clr = 1;
      step();
      bus.time_clr = 0;
      bus.time_en = 1;
      for (int i = 1; i <= 64; i++) begin
         step();
         if (bus.time_late) begin n++; at = i; end
         total++;
         if (got_v() !== want_v()) begin
            bad++;
            $display("FAIL time_sat_cyc%0d: got %h want %h", i, got_v(), want_v());
         end
      end
      total++;
      if (n != 1 || at != 24 || bus.time_ms !== 10'(LATE)) begin
         bad++;
         $display("FAIL time_late_once: got %0d pulses at %0d ms %0d, want 1 at 24 ms 6", n, at, bus.time_ms);
      end
      bus.time_en = 0;
   endtask
   task automatic test_clr_priority();
      int at = -1;
      bus.time_clr = 1;
      step();
      bus.time_clr = 0;
      bus.time_en = 1;
      for (int i = 0; i < 40 && bus.time_ms != 10'd5; i++) step();
      total++;
      if (bus.time_ms !== 10'd5) begin
         bad++;
         $display("FAIL clr_pri_reach5: got %0d want 5", bus.time_ms);
      end
      bus.time_clr = 1;
      step();
      bus.time_clr = 0;
      total++;
      if (bus.time_ms !== 10'd0 || got_v() !== want_v()) begin
         bad++;
         $display("FAIL clr_priority: got %0d want 0", bus.time_ms);
      end
      for (int i = 1; i <= 6; i++) begin
         step();
         if (bus.time_ms == 10'd1 && at < 0) at = i;
      end
      total++;
      if (at != 4) begin
         bad++;
         $display("FAIL clr_first_inc: got cycle %0d want 4", at);
      end
      bus.time_en = 0;
   endtask
   task automatic test_reset_abort();
      int n = 0;
      bus.start_rwait = 1;
      step();
      bus.start_rwait = 0;
      repeat (8) step();
      #2 rst = 0;
      #1 model_rst();
      total++;
      if (got_v() !== 13'd0) begin
         bad++;
         $display("FAIL abort_async: got %h want 0", got_v());
      end
      step();
      rst = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (got_v() != 13'd0) n++;
      end
      total++;
      if (n != 0) begin
         bad++;
         $display("FAIL abort_quiet: got %0d nonzero cycles want 0", n);
      end
   endtask
   task automatic test_restart();
      int n = 0, at = -1, tgt;
      bus.start_rwait = 1;
      step();
      bus.start_rwait = 0;
      repeat (9) step();
      bus.start_rwait = 1;
      step();
      bus.start_rwait = 0;
      tgt = r_due - e;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (bus.rwait_done) begin n++; at = i; end
         total++;
         if (got_v() !== want_v()) begin
            bad++;
            $display("FAIL restart_cyc%0d: got %h want %h", i, got_v(), want_v());
         end
      end
      total++;
      if (n != 1 || at != tgt) begin
         bad++;
         $display("FAIL restart_single: got %0d pulses at %0d want 1 at %0d", n, at, tgt);
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         bus.start_rwait = $urandom_range(0, 39) == 0;
         bus.start_wait5 = $urandom_range(0, 49) == 0;
         bus.time_clr = $urandom_range(0, 59) == 0;
         bus.time_en = $urandom_range(0, 3) != 0;
         step();
         total++;
         if (got_v() !== want_v()) begin
            bad++;
            $display("FAIL random_cyc%0d: got %h want %h", i, got_v(), want_v());
         end
      end
      drive_idle();
   endtask
   initial begin
      drive_idle();
      do_reset();
      test_first_rwait();
      test_wait5();
      test_time_sat();
      test_clr_priority();
      test_reset();
      test_reset_abort();
      test_restart();
      test_random();
      do_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
